riscv32ima_fetch: RTL and testbench
===================================

Name: riscv32ima_fetch

Overview:
Instruction fetch stage of riscv32ima_core. It drives the core's instruction-memory port (i_*) toward the synchronous 64-bit memory model. It splits each returned 64-bit line into two 32-bit instructions, tags each with its PC, and buffers them in a small FIFO. Decode consumes that FIFO over a valid/ready handshake; branch/jump redirects from execute flush the stage and restart fetch.

Parameters:
ADDR_WIDTH, 32, byte-address width of i_addr and PCs
DATA_WIDTH, 64, memory line width (fixed at 64; two instructions per line)
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
i_ncs  output  1  memory chip select, active low
i_nwe  output  1  memory write enable, active low; constant 1
i_addr  output  ADDR_WIDTH  line address, bits [2:0] always 0
i_wdata  output  DATA_WIDTH  constant 0
i_wmask  output  DATA_WIDTH  constant 0
i_rdata  input  DATA_WIDTH  read data, bits [31:0] = word at i_addr, [63:32] = i_addr+4
i_stall  input  1  active-low stall: 1 = memory proceeds, 0 = hold request/response
redir_valid  input  1  redirect strobe from execute
redir_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode accepts head
inst_data  output  32  instruction at head
inst_pc  output  ADDR_WIDTH  PC of head

Behaviour:
- Reset (async assert): i_ncs=1, i_nwe=1, i_addr={RESET_PC[31:3],3'b0}, i_wdata=0, i_wmask=0, inst_valid=0, inst_data=0, inst_pc=0, FIFO empty, fetch_pc=RESET_PC, FSM=IDLE.
- Request accepted at a rising edge where i_ncs=0 and i_stall=1. i_addr and i_ncs are held stable while i_stall=0.
- Response: i_rdata is valid in the first cycle after acceptance in which i_stall=1. It is captured at that edge. At most one request is outstanding.
- Issue rule: assert i_ncs=0 only if free FIFO entries, counted after any response enqueue in the same cycle and ignoring same-cycle dequeue, are >= 2. A new request may be issued in the response cycle.
- Split: the low word goes in first with pc=line, then the high word with pc=line+4. If fetch_pc[2]=1 (redirect to an odd word), the low word is dropped and only the high word is enqueued. fetch_pc then advances to line+8.
- FSM states:
  - IDLE: reset exit; go to REQ next cycle.
  - REQ: i_ncs=0; on accept go to WAIT.
  - WAIT: on response, enqueue, then go to REQ if room, else HOLD.
  - HOLD: i_ncs=1; go to REQ when room.
  - DROP: discard one in-flight response, then go to REQ.
- Redirect (redir_valid=1 at an edge, any state):
  - FIFO is flushed the same edge; inst_valid=0 next cycle.
  - fetch_pc={redir_pc[31:2],2'b0}.
  - If a request is accepted-but-unanswered, or accepted at this same edge, go to DROP. Otherwise go to REQ with i_addr=redir_pc line.
  - A response arriving on the redirect edge is discarded.
- Redirect has priority over enqueue and dequeue in the same cycle. A dequeue on the redirect edge is still considered accepted by decode.
- FIFO: up to 2 enqueues and 1 dequeue per cycle. Pointers wrap modulo FIFO_DEPTH. Full never overflows, guaranteed by the issue rule. When empty, inst_valid=0 and there is no bypass (first instruction visible the cycle after capture).
- PC arithmetic is modulo 2^ADDR_WIDTH; line 32'hFFFF_FFF8 wraps to 0.
- Reset mid-request: all state is cleared immediately; a late response is ignored because FSM=IDLE.

Decomposition:
- Package riscv32ima_pkg:
  - ADDR_WIDTH/DATA_WIDTH constants
  - fetch_state_e enum {IDLE, REQ, WAIT, HOLD, DROP}
  - fetch_entry_t struct {pc[31:0], inst[31:0]}
  - INST_BYTES=4 and LINE_BYTES=8 constants
- Sub-module riscv32ima_fetch_fifo: dual-enqueue/single-dequeue FIFO of fetch_entry_t with flush input and free_count output. The FSM and address logic stay in the top.

Test Plan:
- Reset release, i_stall=1, ready=1, memory word[0..3]=0x00000013,0x00100093,0x00200113,0x00300193 → first request addr 0x0 one cycle after reset release; decode sees pc 0x0,0x4,0x8,0xC with matching data in order.
- inst_ready=0 from reset → exactly two requests (0x0, 0x8) issued, then i_ncs stays 1 with FIFO full (4 entries). Raising ready drains pc 0x0..0xC, then fetch resumes at 0x10.
- Redirect to 0x104 while a request to 0x10 is outstanding → 0x10 response discarded (DROP), next request 0x100, decode sees only pc 0x104 then 0x108.
- i_stall=0 for 3 cycles during REQ and again during WAIT → i_addr/i_ncs held stable, no duplicate enqueue, instruction order unchanged.
- redir_valid, response and dequeue on the same edge → FIFO empty next cycle, response not enqueued, fetch restarts at redirect line.
- Redirect to 0xFFFF_FFF8 → pc 0xFFFF_FFF8, 0xFFFF_FFFC, then next request addr 0x0.

Source files
------------

// File: rtl/riscv32ima_fetch_pkg.sv
// riscv32ima_pkg: shared widths, fetch FSM states and the fetch buffer entry type
package riscv32ima_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int INST_BYTES = 4;
  localparam int LINE_BYTES = 8;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/riscv32ima_fetch_if.sv
// riscv32ima_fetch_if: instruction-memory port (i_*) plus decode handshake (inst_*); master = fetch side
interface riscv32ima_fetch_if #(
  parameter int ADDR_WIDTH = riscv32ima_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = riscv32ima_pkg::DATA_WIDTH
);
  logic                  i_ncs;
  logic                  i_nwe;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] i_wmask;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_stall;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [31:0]           inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  modport master (
    output i_ncs, i_nwe, i_addr, i_wdata, i_wmask, inst_valid, inst_data, inst_pc,
    input  i_rdata, i_stall, inst_ready
  );
  modport slave (
    input  i_ncs, i_nwe, i_addr, i_wdata, i_wmask, inst_valid, inst_data, inst_pc,
    output i_rdata, i_stall, inst_ready
  );
endinterface

// File: rtl/riscv32ima_fetch_fifo.sv
// riscv32ima_fetch_fifo: 2-in/1-out entry buffer; ports clk rst flush enq_cnt enq0 enq1 deq -> valid head free_count
module riscv32ima_fetch_fifo
  import riscv32ima_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [1:0]   enq_cnt,
  input  fetch_entry_t enq0,
  input  fetch_entry_t enq1,
  input  logic         deq,
  output logic         valid,
  output fetch_entry_t head,
  output logic [PW:0]  free_count
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic pop;
  assign valid = count != '0;
  assign head = mem[rptr];
  assign free_count = (PW+1)'(DEPTH) - count;
  assign pop = deq && valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + PW'(enq_cnt);
      rptr <= rptr + PW'(pop);
      count <= count + (PW+1)'(enq_cnt) - (PW+1)'(pop);
    end
  always_ff @(posedge clk) begin
    if (enq_cnt != 2'd0) mem[wptr] <= enq0;
    if (enq_cnt == 2'd2) mem[wptr + PW'(1)] <= enq1;
  end
endmodule

// File: rtl/riscv32ima_fetch.sv
// riscv32ima_fetch: fetch stage; clk rst redir_valid redir_pc, bus = memory port + decode valid/ready
module riscv32ima_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  riscv32ima_fetch_if.master    bus
);
  import riscv32ima_pkg::*;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] ROOM = (PW+1)'(2);
  fetch_state_e state, next;
  logic [ADDR_WIDTH-1:0] fetch_pc, line, line_hi;
  logic [PW:0] free, free_after;
  logic [1:0] enq_cnt;
  logic accept, in_flight, resp, valid;
  fetch_entry_t enq0, enq1, head;
  assign line = {fetch_pc[ADDR_WIDTH-1:3], 3'b0};
  assign line_hi = line + ADDR_WIDTH'(INST_BYTES);
  assign bus.i_ncs = !(state == REQ && free >= ROOM);
  assign bus.i_nwe = 1'b1;
  assign bus.i_addr = line;
  assign bus.i_wdata = {DATA_WIDTH{1'b0}};
  assign bus.i_wmask = {DATA_WIDTH{1'b0}};
  assign accept = !bus.i_ncs && bus.i_stall;
  assign in_flight = state == WAIT || state == DROP;
  assign resp = in_flight && bus.i_stall;
  assign enq_cnt = (state == WAIT && resp && !redir_valid) ? (fetch_pc[2] ? 2'd1 : 2'd2) : 2'd0;
  assign free_after = free - (PW+1)'(enq_cnt);
  assign enq0 = fetch_pc[2] ? '{pc: line_hi, inst: bus.i_rdata[63:32]} : '{pc: line, inst: bus.i_rdata[31:0]};
  assign enq1 = '{pc: line_hi, inst: bus.i_rdata[63:32]};
  assign bus.inst_valid = valid;
  assign bus.inst_data = valid ? head.inst : '0;
  assign bus.inst_pc = valid ? head.pc : '0;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = REQ;
      REQ:     next = accept ? WAIT : REQ;
      WAIT:    next = !resp ? WAIT : free_after >= ROOM ? REQ : HOLD;
      HOLD:    next = free >= ROOM ? REQ : HOLD;
      DROP:    next = resp ? REQ : DROP;
      default: next = IDLE;
    endcase
    if (redir_valid) next = (accept || (in_flight && !resp)) ? DROP : REQ;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= next;
      if (redir_valid) fetch_pc <= {redir_pc[ADDR_WIDTH-1:2], 2'b0};
      else if (enq_cnt != 2'd0) fetch_pc <= line + ADDR_WIDTH'(LINE_BYTES);
    end
  riscv32ima_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redir_valid),
    .enq_cnt(enq_cnt),
    .enq0(enq0),
    .enq1(enq1),
    .deq(bus.inst_ready),
    .valid(valid),
    .head(head),
    .free_count(free)
  );
endmodule

// File: tb/tb_riscv32ima_fetch.sv
// tb_riscv32ima_fetch: directed + random checks of fetch against a memory model and an in-order PC stream model
module tb_riscv32ima_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  int checks = 0;
  int errors = 0;
  int consumed = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] req_log[$];
  logic [31:0] deq_log[$];
  logic pending = 1'b0;
  logic [31:0] pend_addr = '0;
  logic hold = 1'b0;
  logic [31:0] hold_addr = '0;

  riscv32ima_fetch_if bus ();

  riscv32ima_fetch dut (
    .clk(clk),
    .rst(rst),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_0193;
      default: return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  assign bus.i_rdata = {word(pend_addr + 32'd4), word(pend_addr)};

  always @(posedge clk or posedge rst)
    if (rst) pending <= 1'b0;
    else begin
      if (pending && bus.i_stall) pending <= 1'b0;
      if (!bus.i_ncs && bus.i_stall) begin
        pending <= 1'b1;
        pend_addr <= bus.i_addr;
      end
    end

  always @(negedge clk)
    if (rst) begin
      exp_pc = 32'h0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_ncs", 32'(bus.i_ncs), 32'd0);
        chk("hold_addr", bus.i_addr, hold_addr);
      end
      hold = !bus.i_ncs && !bus.i_stall && !redir_valid;
      hold_addr = bus.i_addr;
      if (!bus.i_ncs) begin
        chk("addr_align", 32'(bus.i_addr[2:0]), 32'd0);
        if (bus.i_stall) req_log.push_back(bus.i_addr);
      end
      if (bus.inst_valid && bus.inst_ready) begin
        chk("stream_pc", bus.inst_pc, exp_pc);
        chk("stream_data", bus.inst_data, word(exp_pc));
        deq_log.push_back(bus.inst_pc);
        consumed++;
        exp_pc += 32'd4;
      end
      if (redir_valid) exp_pc = {redir_pc[31:2], 2'b00};
    end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ncs", 32'(bus.i_ncs), 32'd1);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_addr", bus.i_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    deq_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_deq(input int n);
    int k = 0;
    while (deq_log.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (deq_log.size() < n) chk("deq_timeout", 32'(deq_log.size()), 32'(n));
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (req_log.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (req_log.size() < n) chk("req_timeout", 32'(req_log.size()), 32'(n));
  endtask

  initial begin
    bus.i_stall = 1'b1;
    bus.inst_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_nwe", 32'(bus.i_nwe), 32'd1);
    chk("rst_wdata", bus.i_wdata[31:0] | bus.i_wdata[63:32], 32'd0);
    chk("rst_wmask", bus.i_wmask[31:0] | bus.i_wmask[63:32], 32'd0);
    chk("rst_data", bus.inst_data, 32'd0);
    chk("rst_pc", bus.inst_pc, 32'd0);
    do_reset();
    chk("t1_idle_ncs", 32'(bus.i_ncs), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_req_ncs", 32'(bus.i_ncs), 32'd0);
    chk("t1_req_addr", bus.i_addr, 32'h0);
    wait_deq(4);
    for (int i = 0; i < 4; i++) chk("t1_pc", deq_log[i], 32'(4 * i));

    bus.inst_ready = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_req0", req_log[0], 32'h0);
    chk("t2_req1", req_log[1], 32'h8);
    chk("t2_ncs_idle", 32'(bus.i_ncs), 32'd1);
    chk("t2_valid", 32'(bus.inst_valid), 32'd1);
    chk("t2_head_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    wait_deq(4);
    for (int i = 0; i < 4; i++) chk("t2_pc", deq_log[i], 32'(4 * i));
    wait_req(3);
    chk("t2_resume", req_log[2], 32'h10);

    bus.inst_ready = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    bus.inst_ready = 1'b1;
    wait_req(3);
    chk("t3_req", req_log[2], 32'h10);
    bus.i_stall = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 32'h104;
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
    bus.i_stall = 1'b1;
    req_log.delete();
    deq_log.delete();
    chk("t3_flushed", 32'(bus.inst_valid), 32'd0);
    wait_req(1);
    chk("t3_req_after", req_log[0], 32'h100);
    wait_deq(2);
    chk("t3_pc0", deq_log[0], 32'h104);
    chk("t3_pc1", deq_log[1], 32'h108);

    bus.i_stall = 1'b0;
    do_reset();
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_ncs_held", 32'(bus.i_ncs), 32'd0);
    chk("t4_addr_held", bus.i_addr, 32'h0);
    chk("t4_no_req", 32'(req_log.size()), 32'd0);
    bus.i_stall = 1'b1;
    @(posedge clk);
    #1;
    bus.i_stall = 1'b0;
    chk("t4_one_req", 32'(req_log.size()), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_wait_valid", 32'(bus.inst_valid), 32'd0);
    chk("t4_wait_ncs", 32'(bus.i_ncs), 32'd1);
    bus.i_stall = 1'b1;
    wait_deq(4);
    for (int i = 0; i < 4; i++) chk("t4_pc", deq_log[i], 32'(4 * i));

    do_reset();
    wait_req(2);
    chk("t5_valid", 32'(bus.inst_valid), 32'd1);
    chk("t5_head", bus.inst_pc, 32'h4);
    redir_valid = 1'b1;
    redir_pc = 32'h200;
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
    req_log.delete();
    deq_log.delete();
    chk("t5_flushed", 32'(bus.inst_valid), 32'd0);
    wait_req(1);
    chk("t5_req", req_log[0], 32'h200);
    wait_deq(2);
    chk("t5_pc0", deq_log[0], 32'h200);
    chk("t5_pc1", deq_log[1], 32'h204);

    do_reset();
    repeat (5) @(posedge clk);
    #1;
    redir_valid = 1'b1;
    redir_pc = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
    req_log.delete();
    deq_log.delete();
    wait_deq(2);
    chk("t6_pc0", deq_log[0], 32'hFFFF_FFF8);
    chk("t6_pc1", deq_log[1], 32'hFFFF_FFFC);
    wait_req(2);
    chk("t6_req0", req_log[0], 32'hFFFF_FFF8);
    chk("t6_wrap", req_log[1], 32'h0);

    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.i_stall = $urandom_range(0, 3) != 0;
      bus.inst_ready = $urandom_range(0, 9) < 7;
      redir_valid = $urandom_range(0, 99) < 3;
      redir_pc = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      if (c == 1500) begin
        redir_valid = 1'b0;
        do_reset();
      end
      @(posedge clk);
      #1;
    end
    redir_valid = 1'b0;
    chk("rand_progress", 32'(consumed > 300), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
